// File: rtl/ws2811_frame_sequencer_if.sv
// Pixel-word handshake between an upstream pixel source and the WS2811 sequencer.
interface ws2811_frame_sequencer_if;
  logic [23:0] pixelDataIN;
  logic        pixelValidIN;
  logic        pixelReadyOUT;

  modport master (
    output pixelDataIN,
    output pixelValidIN,
    input  pixelReadyOUT
  );

  modport slave (
    input  pixelDataIN,
    input  pixelValidIN,
    output pixelReadyOUT
  );
endinterface

// File: rtl/ws2811_frame_sequencer.sv
// WS2811 frame sequencer: prefetches 24-bit pixel words into a one-entry holding
// register, serialises them MSB first with per-bit high/low timing, then holds
// the line low for the latch gap.
module ws2811_frame_sequencer #(
  parameter int BIT_CYCLES   = 63,
  parameter int T0H_CYCLES   = 18,
  parameter int T1H_CYCLES   = 35,
  parameter int RESET_CYCLES = 2500,
  parameter int PIXELS       = 60,
  localparam int IDX_W       = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
  input  logic                     clkIN,
  input  logic                     nResetIN,
  input  logic                     startIN,
  ws2811_frame_sequencer_if.slave  pixelBus,
  output logic [IDX_W-1:0]         pixelIndexOUT,
  output logic                     dataOUT,
  output logic                     busyOUT,
  output logic                     frameDoneOUT,
  output logic                     underrunOUT
);

  localparam int BIT_W = $clog2(BIT_CYCLES);
  localparam int LAT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int ACC_W = $clog2(PIXELS + 1);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] T0H_V    = BIT_W'(T0H_CYCLES);
  localparam logic [BIT_W-1:0] T1H_V    = BIT_W'(T1H_CYCLES);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXELS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = ACC_W'(PIXELS);
  localparam logic [4:0]       BIT_IDX_LAST = 5'd23;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  state_t           state;
  state_t           stateNext;
  logic [23:0]      holdReg;
  logic [23:0]      shiftReg;
  logic             holdFull;
  logic [ACC_W-1:0] acceptCount;
  logic [BIT_W-1:0] bitCnt;
  logic [4:0]       bitIdx;
  logic [LAT_W-1:0] latchCnt;

  logic ready;
  logic transfer;
  logic frameStart;
  logic bitEnd;
  logic pixelEnd;
  logic latchEnd;
  logic loadShift;
  logic underrunSet;
  logic frameDoneSet;

  assign ready = ((state == FETCH) || (state == SEND)) && !holdFull && (acceptCount < ACC_MAX);
  assign pixelBus.pixelReadyOUT = ready;
  assign transfer   = pixelBus.pixelValidIN && ready;
  assign frameStart = (state == IDLE) && startIN;
  assign busyOUT    = (state != IDLE);
  assign bitEnd     = (bitCnt == BIT_LAST);
  assign pixelEnd   = bitEnd && (bitIdx == BIT_IDX_LAST);
  assign latchEnd   = (latchCnt == LAT_LAST);

  // State register.
  always_ff @(posedge clkIN) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (!nResetIN) state <= IDLE;
    else           state <= stateNext;
  end

  // Next-state decode plus the single-cycle control strobes for the datapath.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    stateNext    = state;
    loadShift    = 1'b0;
    underrunSet  = 1'b0;
    frameDoneSet = 1'b0;
    case (state)
      IDLE: begin
        if (startIN) stateNext = FETCH;
      end
      FETCH: begin
        if (holdFull) begin
          loadShift = 1'b1;
          stateNext = SEND;
        end
      end
      SEND: begin
        if (pixelEnd) begin
          if (pixelIndexOUT == IDX_LAST) begin
            stateNext = LATCH;
          end else if (holdFull) begin
            loadShift = 1'b1;
          end else begin
            underrunSet = 1'b1;
            stateNext   = LATCH;
          end
        end
      end
      LATCH: begin
        if (latchEnd) begin
          frameDoneSet = 1'b1;
          stateNext    = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Counters, holding-register flag and registered line/pulse outputs.
  always_ff @(posedge clkIN) begin
    if (!nResetIN) begin
      holdFull      <= 1'b0;
      acceptCount   <= '0;
      bitCnt        <= '0;
      bitIdx        <= '0;
      latchCnt      <= '0;
      pixelIndexOUT <= '0;
      dataOUT       <= 1'b0;
      frameDoneOUT  <= 1'b0;
      underrunOUT   <= 1'b0;
    end else begin
      dataOUT      <= (state == SEND) && (bitCnt < (shiftReg[23] ? T1H_V : T0H_V));
      underrunOUT  <= underrunSet;
      frameDoneOUT <= frameDoneSet;

      if (transfer)       holdFull <= 1'b1;
      else if (loadShift) holdFull <= 1'b0;

      if (frameStart)    acceptCount <= '0;
      else if (transfer) acceptCount <= acceptCount + 1'b1;

      if (frameStart)                       pixelIndexOUT <= '0;
      else if ((state == SEND) && loadShift) pixelIndexOUT <= pixelIndexOUT + 1'b1;

      if (state == SEND) begin
        bitCnt <= bitEnd ? '0 : bitCnt + 1'b1;
        if (bitEnd) bitIdx <= pixelEnd ? '0 : bitIdx + 1'b1;
      end else begin
        bitCnt <= '0;
        bitIdx <= '0;
      end

      if (state == LATCH) latchCnt <= latchEnd ? '0 : latchCnt + 1'b1;
      else                latchCnt <= '0;
    end
  end

  // Pixel data path: holding register and output shifter.
  always_ff @(posedge clkIN) begin
    // NOTE: data registers are left unreset; holdFull and the state qualify every use of them.
    if (transfer) holdReg <= pixelBus.pixelDataIN;
    if (loadShift)                       shiftReg <= holdReg;
    else if ((state == SEND) && bitEnd)  shiftReg <= {shiftReg[22:0], 1'b0};
  end

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Self-checking bench for ws2811_frame_sequencer: randomized pixel source with
// stalls, and a reference model that rebuilds the expected line waveform from
// the pixel words and the bit-timing rules.
module tb_ws2811_frame_sequencer;
  localparam int BIT_CYCLES   = 10;
  localparam int T0H          = 3;
  localparam int T1H          = 6;
  localparam int RESET_CYCLES = 20;
  localparam int PIXELS       = 2;
  localparam int IDX_W        = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int PIXEL_CYCLES = 24 * BIT_CYCLES;

  logic             clkIN = 1'b0;
  logic             nResetIN = 1'b0;
  logic             startIN = 1'b0;
  logic [IDX_W-1:0] pixelIndexOUT;
  logic             dataOUT;
  logic             busyOUT;
  logic             frameDoneOUT;
  logic             underrunOUT;

  ws2811_frame_sequencer_if pixelBus();

  ws2811_frame_sequencer #(
    .BIT_CYCLES  (BIT_CYCLES),
    .T0H_CYCLES  (T0H),
    .T1H_CYCLES  (T1H),
    .RESET_CYCLES(RESET_CYCLES),
    .PIXELS      (PIXELS)
  ) dut (
    .clkIN        (clkIN),
    .nResetIN     (nResetIN),
    .startIN      (startIN),
    .pixelBus     (pixelBus),
    .pixelIndexOUT(pixelIndexOUT),
    .dataOUT      (dataOUT),
    .busyOUT      (busyOUT),
    .frameDoneOUT (frameDoneOUT),
    .underrunOUT  (underrunOUT)
  );

  always #5 clkIN = ~clkIN;

  int cyc = 0;
  always @(posedge clkIN) cyc++;

  int checksRun = 0;
  int checksPassed = 0;

  task automatic check(input string tag, input int got, input int exp);
    checksRun++;
    if (got == exp) checksPassed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Pixel source: offers queued words with random stalls; optionally keeps
  // valid high with junk data once the queue is empty.
  logic [23:0] srcQ[$];
  bit          holdValid = 1'b0;
  int          stallPct = 0;
  int          xferCount = 0;
  int          readyViol = 0;
  int          firstXferEdge = -1;

  initial begin : source
    bit xfer;
    bit prevXfer;
    prevXfer = 1'b0;
    pixelBus.pixelValidIN = 1'b0;
    pixelBus.pixelDataIN  = '0;
    forever begin
      @(negedge clkIN);
      xfer = pixelBus.pixelValidIN && pixelBus.pixelReadyOUT && nResetIN;
      if (prevXfer && pixelBus.pixelReadyOUT) readyViol++;
      prevXfer = xfer;
      if (xfer) begin
        xferCount++;
        if (firstXferEdge < 0) firstXferEdge = cyc + 1;
      end
      @(posedge clkIN);
      #1;
      if (xfer && srcQ.size() > 0) void'(srcQ.pop_front());
      if (srcQ.size() > 0 && $urandom_range(99) >= stallPct) begin
        pixelBus.pixelValidIN = 1'b1;
        pixelBus.pixelDataIN  = srcQ[0];
      end else if (holdValid && srcQ.size() == 0) begin
        pixelBus.pixelValidIN = 1'b1;
        pixelBus.pixelDataIN  = 24'($urandom);
      end else begin
        pixelBus.pixelValidIN = 1'b0;
        pixelBus.pixelDataIN  = 24'($urandom);
      end
    end
  end

  logic [23:0] nextWords[$];

  // Runs one frame from nextWords and checks the line against the model.
  // midStartAt: sample index where a stray start is pulsed (-1 none).
  // chainStart: assert start in the frameDone cycle. resetAt: reset at that sample.
  task automatic runFrame(input string tag, input bit issueStart, input int midStartAt,
                          input bit chainStart, input int resetAt);
    logic [23:0] words[$];
    bit          expWave[$];
    bit          seen;
    int          nSent, waveLen, idx, riseCyc, doneIdx, underrunIdx, underrunCnt;
    int          waveMism, pixMism, busyAtDone;

    words = nextWords;
    nSent = (words.size() < PIXELS) ? words.size() : PIXELS;
    expWave.delete();
    for (int p = 0; p < nSent; p++)
      for (int b = 23; b >= 0; b--)
        for (int c = 0; c < BIT_CYCLES; c++)
          expWave.push_back(c < (words[p][b] ? T1H : T0H));
    waveLen = expWave.size();

    xferCount = 0;
    readyViol = 0;
    firstXferEdge = -1;
    srcQ = words;
    if (issueStart) begin
      @(posedge clkIN);
      #1 startIN = 1'b1;
      @(posedge clkIN);
      #1 startIN = 1'b0;
    end

    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clkIN);
      if (dataOUT) seen = 1'b1;
    end
    if (!seen) begin
      check({tag, "_rise_timeout"}, 0, 1);
      holdValid = 1'b0;
      srcQ.delete();
      return;
    end
    riseCyc = cyc;

    doneIdx = -1;
    underrunIdx = -1;
    underrunCnt = 0;
    waveMism = 0;
    pixMism = 0;
    busyAtDone = -1;
    for (idx = 0; idx < waveLen + RESET_CYCLES + 100; idx++) begin
      if (idx > 0) @(negedge clkIN);
      if (dataOUT != ((idx < waveLen) ? expWave[idx] : 1'b0)) waveMism++;
      if (idx < waveLen - 1 && pixelIndexOUT != IDX_W'((idx + 1) / PIXEL_CYCLES)) pixMism++;
      if (underrunOUT) begin
        underrunCnt++;
        underrunIdx = idx;
      end
      if (idx == midStartAt) startIN = 1'b1;
      else if (idx == midStartAt + 1) startIN = 1'b0;
      if (idx == resetAt) begin
        nResetIN = 1'b0;
        @(negedge clkIN);
        check({tag, "_rst_data"}, dataOUT, 0);
        check({tag, "_rst_busy"}, busyOUT, 0);
        check({tag, "_rst_ready"}, pixelBus.pixelReadyOUT, 0);
        check({tag, "_rst_pixidx"}, pixelIndexOUT, 0);
        check({tag, "_rst_done"}, frameDoneOUT, 0);
        nResetIN = 1'b1;
        holdValid = 1'b0;
        srcQ.delete();
        return;
      end
      if (frameDoneOUT) begin
        doneIdx = idx;
        busyAtDone = busyOUT;
        break;
      end
    end

    if (doneIdx < 0) begin
      check({tag, "_done_timeout"}, 0, 1);
      holdValid = 1'b0;
      srcQ.delete();
      return;
    end

    check({tag, "_latency"}, riseCyc - firstXferEdge, 2);
    check({tag, "_wave"}, waveMism, 0);
    check({tag, "_pixidx"}, pixMism, 0);
    check({tag, "_done_at"}, doneIdx, waveLen + RESET_CYCLES - 1);
    check({tag, "_underrun_at"}, underrunIdx, (nSent < PIXELS) ? waveLen - 1 : -1);
    check({tag, "_underrun_cnt"}, underrunCnt, (nSent < PIXELS) ? 1 : 0);
    check({tag, "_xfers"}, xferCount, nSent);
    check({tag, "_ready_hold"}, readyViol, 0);
    check({tag, "_busy_done"}, busyAtDone, 0);
    holdValid = 1'b0;
    srcQ.delete();

    if (chainStart) begin
      startIN = 1'b1;
      @(posedge clkIN);
      #1 startIN = 1'b0;
      @(negedge clkIN);
      check({tag, "_chain_busy"}, busyOUT, 1);
    end else begin
      @(negedge clkIN);
      check({tag, "_done_pulse"}, frameDoneOUT, 0);
      check({tag, "_idle_busy"}, busyOUT, 0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    nResetIN = 1'b0;
    repeat (3) @(posedge clkIN);
    @(negedge clkIN);
    check("reset_data", dataOUT, 0);
    check("reset_busy", busyOUT, 0);
    check("reset_ready", pixelBus.pixelReadyOUT, 0);
    check("reset_pixidx", pixelIndexOUT, 0);
    check("reset_done", frameDoneOUT, 0);
    check("reset_underrun", underrunOUT, 0);
    nResetIN = 1'b1;

    stallPct = 0;
    nextWords = '{24'hFFFFFF, 24'h000000};
    runFrame("ones_zeros", 1'b1, -1, 1'b0, -1);

    nextWords = '{24'hA50001, 24'h5A3C81};
    runFrame("pattern", 1'b1, -1, 1'b0, -1);

    nextWords = '{24'h123456};
    runFrame("underrun", 1'b1, -1, 1'b0, -1);

    holdValid = 1'b1;
    nextWords = '{24'($urandom), 24'($urandom)};
    runFrame("valid_held", 1'b1, -1, 1'b0, -1);

    nextWords = '{24'($urandom), 24'($urandom)};
    runFrame("mid_start", 1'b1, 100, 1'b1, -1);
    nextWords = '{24'($urandom), 24'($urandom)};
    runFrame("chained", 1'b0, -1, 1'b0, -1);

    nextWords = '{24'($urandom), 24'($urandom)};
    runFrame("reset_mid", 1'b1, -1, 1'b0, PIXEL_CYCLES + 1);
    nextWords = '{24'($urandom), 24'($urandom)};
    runFrame("after_reset", 1'b1, -1, 1'b0, -1);

    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(PIXELS, 1);
      nextWords.delete();
      for (int k = 0; k < n; k++) nextWords.push_back(24'($urandom));
      stallPct = $urandom_range(60, 0);
      runFrame($sformatf("rand%0d", f), 1'b1, -1, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
